hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the combinational load-use detector. Decides stall, bubble, flush and freeze for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Adds x0 and operand-use qualification, multi-cycle load-use stalls, branch-flush sequencing and a data-memory wait freeze.
- Driven by an internal state machine.
- Sits beside the ID stage. Its outputs gate the PC register, the IF/ID register, the control mux into ID/EX and the flush inputs of the stage registers.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
- BRANCH_PENALTY, 1, cycles of IF/ID flush per taken branch; legal range 1..3.
- CNT_W, 32, perf counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  REG_AW  destination register of the instruction in EX.
- if_id_rs1  in  REG_AW  source register 1 of the instruction in ID.
- if_id_rs2  in  REG_AW  source register 2 of the instruction in ID.
- if_id_use_rs1  in  1  ID instruction reads rs1.
- if_id_use_rs2  in  1  ID instruction reads rs2.
- ex_branch_taken  in  1  EX redirects the PC this cycle.
- mem_busy  in  1  data memory has not completed the MEM-stage access.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may load.
- ctrl_select  out  1  1 = pass decoded control; 0 = zero control (bubble) into ID/EX.
- if_id_flush  out  1  clear IF/ID.
- id_ex_flush  out  1  clear ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  bubble cycles counted (optional feature).
- flush_cnt  out  CNT_W  flush cycles counted (optional feature).

Behaviour:
- hz = id_ex_mem_read & (id_ex_rd != 0) & ((if_id_use_rs1 & if_id_rs1 == id_ex_rd) | (if_id_use_rs2 & if_id_rs2 == id_ex_rd)). hz is combinational.
- States: RUN, LSTALL, BFLUSH. A 3-bit down-counter cnt drives LSTALL and BFLUSH.
- Default outputs: pc_write=1, if_id_write=1, ctrl_select=1, all flushes 0, pipe_freeze=0.
- Priority, highest first: rst > mem_busy > branch > load-use/LSTALL.
- rst=1:
  - Outputs: pc_write=0, if_id_write=0, ctrl_select=0, if_id_flush=1, id_ex_flush=1, pipe_freeze=0.
  - Next state RUN, cnt=0. Reset mid-stall or mid-flush aborts it.
- mem_busy=1 (any state):
  - Outputs: pipe_freeze=1, pc_write=0, if_id_write=0, ctrl_select=1, no flush.
  - State and cnt hold.
  - A branch or hazard seen during the freeze is acted on in the first non-busy cycle.
- RUN with ex_branch_taken:
  - Outputs: if_id_flush=1, id_ex_flush=1, pc_write=1.
  - Any hz this cycle is ignored, because the dependent instruction is squashed.
  - If BRANCH_PENALTY>1: go to BFLUSH with cnt=BRANCH_PENALTY-1.
- BFLUSH: if_id_flush=1, pc_write=1. Decrement cnt; at cnt==1 return to RUN.
- A taken branch in BFLUSH is illegal (EX holds a bubble). It is ignored.
- RUN with hz:
  - Outputs: pc_write=0, if_id_write=0, ctrl_select=0.
  - If LOAD_STALL_CYCLES>1: go to LSTALL with cnt=LOAD_STALL_CYCLES-1.
- LSTALL: same outputs as RUN with hz, whatever hz is. Decrement cnt; at cnt==1 return to RUN.
- ex_branch_taken in LSTALL is impossible (EX holds a bubble) and is ignored.
- Latency: all responses are combinational in the detecting cycle. State only extends the response into later cycles.
- With default parameters the behaviour equals the legacy single-bubble detector, with x0 and use-qualification added.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments every cycle ctrl_select=0 and rst=0.
  - flush_cnt increments every cycle if_id_flush=1 and rst=0.
  - Both counters wrap at 2^CNT_W and reset to 0.
- Undefined: both ports are present and tied to 0. No counter flops.

Decomposition:
- Shared package: state encoding constants (ST_RUN=0, ST_LSTALL=1, ST_BFLUSH=2), REG_AW default, and a localparam check for the legal ranges of LOAD_STALL_CYCLES and BRANCH_PENALTY.
- One sub-module is natural: hazard_cmp, the combinational hz comparator, parametrised by REG_AW. It is reused later for forwarding.

Test Plan:
- Load x5, then an instruction reading rs1=5 (use=1), defaults -> one cycle with pc_write=0, if_id_write=0, ctrl_select=0, then normal.
- Load x0, then an instruction reading x0; or load x5 followed by an instruction reading rs2=5 with use_rs2=0 -> no stall.
- LOAD_STALL_CYCLES=3, load-use -> exactly 3 bubble cycles; rst asserted in the 2nd bubble -> reset outputs, then RUN.
- BRANCH_PENALTY=2, ex_branch_taken together with hz -> cycle 1: both flushes=1, ctrl_select=1. Cycle 2: if_id_flush=1 only.
- mem_busy high for 4 cycles, with a hazard present -> pipe_freeze=1 for 4 cycles, ctrl_select=1. Stall bubble is issued in the 5th cycle.
- HAZARD_PERF_CNT_EN defined, 3 stall cycles plus 2 flush cycles -> stall_cnt=3, flush_cnt=2. Macro undefined -> both read 0.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_ctrl_unit_pkg: shared state encoding, defaults and parameter range check for the hazard control unit
package hazard_ctrl_unit_pkg;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LSTALL = 2'd1;
  localparam logic [1:0] ST_BFLUSH = 2'd2;
  localparam int REG_AW_DEF = 5;
  function automatic bit params_ok(int load_stall_cycles, int branch_penalty);
    return load_stall_cycles >= 1 && load_stall_cycles <= 7 &&
           branch_penalty >= 1 && branch_penalty <= 3;
  endfunction
endpackage

// File: rtl/hazard_ctrl_unit_cmp.sv
// hazard_cmp: combinational load-use comparator (x0 and operand-use qualified)
// ports: mem_read/rd describe the EX instruction, rs1/rs2/use_rs1/use_rs2 the ID instruction, hz is the hazard flag
module hazard_cmp
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              mem_read,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  output logic              hz
);
  assign hz = mem_read & (rd != '0) & ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: stall/bubble/flush/freeze control for the 5-stage pipeline
// inputs : clk, rst (sync active-high), id_ex_mem_read, id_ex_rd, if_id_rs1/rs2, if_id_use_rs1/rs2, ex_branch_taken, mem_busy
// outputs: pc_write, if_id_write, ctrl_select (0 = bubble), if_id_flush, id_ex_flush, pipe_freeze, stall_cnt, flush_cnt
// HAZARD_PERF_CNT_EN enables the stall/flush cycle counters; otherwise both read 0
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_AW            = REG_AW_DEF,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_PENALTY    = 1,
  parameter int CNT_W             = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_use_rs1,
  input  logic              if_id_use_rs2,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ctrl_select,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam bit PARAMS_OK = params_ok(LOAD_STALL_CYCLES, BRANCH_PENALTY);
  if (!PARAMS_OK) begin : g_bad_params
    $error("hazard_ctrl_unit: LOAD_STALL_CYCLES must be 1..7 and BRANCH_PENALTY 1..3");
  end
  logic       hz;
  logic [1:0] state, state_n;
  logic [2:0] cnt, cnt_n;
  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .mem_read(id_ex_mem_read),
    .rd      (id_ex_rd),
    .rs1     (if_id_rs1),
    .rs2     (if_id_rs2),
    .use_rs1 (if_id_use_rs1),
    .use_rs2 (if_id_use_rs2),
    .hz      (hz)
  );
  // mem_busy holds state so a pending branch or hazard is handled once memory completes
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    ctrl_select = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    state_n     = state;
    cnt_n       = cnt;
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_select = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_n     = ST_RUN;
      cnt_n       = '0;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (state == ST_BFLUSH) begin
      if_id_flush = 1'b1;
      cnt_n       = cnt - 3'd1;
      state_n     = cnt == 3'd1 ? ST_RUN : ST_BFLUSH;
    end else if (state == ST_LSTALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_select = 1'b0;
      cnt_n       = cnt - 3'd1;
      state_n     = cnt == 3'd1 ? ST_RUN : ST_LSTALL;
    end else if (ex_branch_taken) begin
      // the dependent instruction is squashed, so hz is irrelevant here
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_n     = BRANCH_PENALTY > 1 ? ST_BFLUSH : ST_RUN;
      cnt_n       = 3'(BRANCH_PENALTY - 1);
    end else if (hz) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ctrl_select = 1'b0;
      state_n     = LOAD_STALL_CYCLES > 1 ? ST_LSTALL : ST_RUN;
      cnt_n       = 3'(LOAD_STALL_CYCLES - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(!ctrl_select);
      flush_cnt <= flush_cnt + CNT_W'(if_id_flush);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed checks of a default instance and a LOAD_STALL_CYCLES=3/BRANCH_PENALTY=2 instance
module tb_hazard_ctrl_unit;
  // output vector order: {pc_write, if_id_write, ctrl_select, if_id_flush, id_ex_flush, pipe_freeze}
  localparam logic [5:0] RUN = 6'b111000;
  localparam logic [5:0] STL = 6'b000000;
  localparam logic [5:0] RST = 6'b000110;
  localparam logic [5:0] FRZ = 6'b001001;
  localparam logic [5:0] BR  = 6'b111110;
  localparam logic [5:0] BF  = 6'b111100;
  logic clk = 1'b0;
  logic rst, mem_read, use_rs1, use_rs2, br, busy;
  logic [4:0] rd, rs1, rs2;
  logic pw_d, iw_d, cs_d, iff_d, ief_d, fz_d;
  logic pw_p, iw_p, cs_p, iff_p, ief_p, fz_p;
  logic [31:0] sc_d, fc_d, sc_p, fc_p;
  logic [5:0] o_d, o_p;
  int total = 0;
  int bad = 0;
  int ms_d = 0, mf_d = 0, ms_p = 0, mf_p = 0;
  always #5 clk = ~clk;
  assign o_d = {pw_d, iw_d, cs_d, iff_d, ief_d, fz_d};
  assign o_p = {pw_p, iw_p, cs_p, iff_p, ief_p, fz_p};
  hazard_ctrl_unit u_def (
    .clk(clk), .rst(rst), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_use_rs1(use_rs1), .if_id_use_rs2(use_rs2),
    .ex_branch_taken(br), .mem_busy(busy),
    .pc_write(pw_d), .if_id_write(iw_d), .ctrl_select(cs_d),
    .if_id_flush(iff_d), .id_ex_flush(ief_d), .pipe_freeze(fz_d),
    .stall_cnt(sc_d), .flush_cnt(fc_d)
  );
  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(2)) u_p (
    .clk(clk), .rst(rst), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_use_rs1(use_rs1), .if_id_use_rs2(use_rs2),
    .ex_branch_taken(br), .mem_busy(busy),
    .pc_write(pw_p), .if_id_write(iw_p), .ctrl_select(cs_p),
    .if_id_flush(iff_p), .id_ex_flush(ief_p), .pipe_freeze(fz_p),
    .stall_cnt(sc_p), .flush_cnt(fc_p)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(string tag, logic r, logic mr, logic [4:0] d, logic [4:0] s1, logic u1,
                      logic [4:0] s2, logic u2, logic b, logic bz, logic [5:0] ed, logic [5:0] ep);
    @(negedge clk);
    rst = r; mem_read = mr; rd = d; rs1 = s1; use_rs1 = u1; rs2 = s2; use_rs2 = u2; br = b; busy = bz;
    #1;
    chk({tag, "/def"}, 32'(o_d), 32'(ed));
    chk({tag, "/p32"}, 32'(o_p), 32'(ep));
    if (r) begin
      ms_d = 0; mf_d = 0; ms_p = 0; mf_p = 0;
    end else begin
      ms_d += int'(!ed[3]); mf_d += int'(ed[2]);
      ms_p += int'(!ep[3]); mf_p += int'(ep[2]);
    end
  endtask
  task automatic idle(string tag, logic [5:0] ed, logic [5:0] ep);
    step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ed, ep);
  endtask
  task automatic chk_cnts(string tag);
    @(negedge clk);
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "/stall_def"}, sc_d, 32'(ms_d));
    chk({tag, "/flush_def"}, fc_d, 32'(mf_d));
    chk({tag, "/stall_p32"}, sc_p, 32'(ms_p));
    chk({tag, "/flush_p32"}, fc_p, 32'(mf_p));
`else
    chk({tag, "/stall_def"}, sc_d, 32'd0);
    chk({tag, "/flush_def"}, fc_d, 32'd0);
    chk({tag, "/stall_p32"}, sc_p, 32'd0);
    chk({tag, "/flush_p32"}, fc_p, 32'd0);
`endif
  endtask
  initial begin
    rst = 1'b1; mem_read = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; br = 1'b0; busy = 1'b0;
    step("rst", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RST, RST);
    idle("idle", RUN, RUN);
    step("x0", 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, RUN, RUN);
    step("nouse2", 1'b0, 1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, RUN, RUN);
    step("rs2hz", 1'b0, 1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, STL, STL);
    step("rst_mid", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RST, RST);
    idle("after_rst", RUN, RUN);
    step("lu_b1", 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, STL, STL);
    idle("lu_b2", RUN, STL);
    idle("lu_b3", RUN, STL);
    idle("lu_end", RUN, RUN);
    step("br_hz", 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, BR, BR);
    idle("br_2", RUN, BF);
    idle("br_end", RUN, RUN);
    chk_cnts("cnt_mid");
    for (int i = 0; i < 4; i++)
      step("frz", 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, FRZ, FRZ);
    step("frz_rel", 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, STL, STL);
    step("frz_ls", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ, FRZ);
    idle("ls_b2", RUN, STL);
    idle("ls_b3", RUN, STL);
    idle("ls_end", RUN, RUN);
    step("frz_br", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FRZ, FRZ);
    step("br_late", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, BR, BR);
    idle("bf_late", RUN, BF);
    idle("bf_end", RUN, RUN);
    chk_cnts("cnt_end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
